// File: rtl/bias_feed.sv
// bias_feed: accepts raw bias words over valid/ready and aligns each one with a
// saturating left shift. The aligned words are held in a small FIFO. One
// registered bias at a time is presented to the downstream adder, and the
// consumer steps through them with single-cycle bias_next pulses.
module bias_feed #(
    parameter int NUM_WIDTH   = 16,
    parameter int DEPTH_NB    = 3,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [NUM_WIDTH-1:0]   up_bias_data,
    input  logic                   up_bias_valid,
    output logic                   up_bias_ready,
    input  logic                   bias_next,
    output logic [NUM_WIDTH-1:0]   bias,
    output logic                   bias_valid,
    output logic [DEPTH_NB:0]      bias_count
);

    localparam int DEPTH     = 2 ** DEPTH_NB;
    localparam int SHIFT_MAX = 2 ** SHIFT_WIDTH - 1;
    // Wide enough that the largest shift never loses a bit.
    localparam int EXT_W     = NUM_WIDTH + SHIFT_MAX;

    localparam logic [DEPTH_NB:0]    COUNT_FULL = (DEPTH_NB + 1)'(DEPTH);
    localparam logic [DEPTH_NB:0]    COUNT_ZERO = '0;
    localparam logic [DEPTH_NB:0]    COUNT_ONE  = (DEPTH_NB + 1)'(1);
    localparam logic [NUM_WIDTH-1:0] SAT_POS    = {1'b0, {(NUM_WIDTH - 1){1'b1}}};
    localparam logic [NUM_WIDTH-1:0] SAT_NEG    = {1'b1, {(NUM_WIDTH - 1){1'b0}}};

    // FIFO storage. The read side is the registered output bias itself.
    logic [NUM_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_NB-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_NB-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_NB:0]    count_q, count_d;
    logic [NUM_WIDTH-1:0] bias_q;
    logic                 bias_valid_q, bias_valid_d;

    logic                 accept;
    logic                 load;
    logic                 drain;
    logic                 fifo_empty;

    logic [EXT_W-1:0]     ext_word;
    logic [EXT_W-1:0]     shifted_word;
    logic                 overflow;
    logic [NUM_WIDTH-1:0] fmt_word;

    // Ready comes only from the registered count, so it has no path from valid.
    // It is held low while reset is asserted.
    assign up_bias_ready = !rst && (count_q != COUNT_FULL);
    assign accept        = up_bias_valid && up_bias_ready;
    assign fifo_empty    = (count_q == COUNT_ZERO);

    // The load decision uses the count from before the edge. A word accepted
    // into an empty FIFO therefore reaches the output one edge later.
    assign load  = (!bias_valid_q || bias_next) && !fifo_empty;
    // The consumer releases the last bias and nothing is waiting behind it.
    assign drain = bias_next && bias_valid_q && fifo_empty;

    // Sign-extend the word, shift it, and clamp it if significant bits
    // would otherwise fall out of the NUM_WIDTH window.
    always_comb begin
        ext_word     = {{SHIFT_MAX{up_bias_data[NUM_WIDTH-1]}}, up_bias_data};
        shifted_word = ext_word << cfg_shift;
        // The value fits only if every bit from NUM_WIDTH-1 upward repeats the sign.
        overflow     = (shifted_word[EXT_W-1:NUM_WIDTH-1]
                        != {(SHIFT_MAX + 1){shifted_word[EXT_W-1]}});
        fmt_word     = shifted_word[NUM_WIDTH-1:0];
        if (overflow) begin
            fmt_word = shifted_word[EXT_W-1] ? SAT_NEG : SAT_POS;
        end
    end

    // Next-state logic for the pointers, occupancy and output-valid flag.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        bias_valid_d = bias_valid_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            bias_valid_d = 1'b1;
        end else if (drain) begin
            bias_valid_d = 1'b0;
        end

        // An accept and a load on the same edge cancel in the count.
        case ({accept, load})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bias_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            bias_valid_q <= bias_valid_d;
        end
    end

    // FIFO write port. Storage is not reset: reset empties the FIFO through
    // the pointers, so old contents are never read again.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= fmt_word;
        end
    end

    // Output register. It is a registered read of the FIFO head, and it
    // changes only on a load or a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_q <= '0;
        end else if (load) begin
            bias_q <= mem[rd_ptr_q];
        end
    end

    assign bias       = bias_q;
    assign bias_valid = bias_valid_q;
    assign bias_count = count_q;

endmodule

// File: doc/bias_feed.md
# bias_feed

Producer side of the bias path: accepts raw per-kernel bias words from the configuration stream over a valid/ready handshake, aligns each to the accumulator fixed-point position by a saturating left shift, buffers them in a small FIFO, and presents one stable pre-formatted bias to the downstream bias adder. The consumer advances to the next bias with a single-cycle `bias_next` pulse at the end of each output kernel/map.

## Interface
- `NUM_WIDTH`, 16: bias and datapath width, signed two's complement.
- `DEPTH_NB`, 3: log2 of FIFO depth; DEPTH = 2**DEPTH_NB = 8 entries (excludes output register).
- `SHIFT_WIDTH`, 4: width of the alignment shift amount.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_shift`  in  SHIFT_WIDTH  left-shift amount applied to a word when it is accepted.
- `up_bias_data`  in  NUM_WIDTH  raw signed bias word.
- `up_bias_valid`  in  1  upstream word valid.
- `up_bias_ready`  out  1  block can accept a word.
- `bias_next`  in  1  consumer done with current bias; advance.
- `bias`  out  NUM_WIDTH  current formatted bias, registered, stable while `bias_valid` high.
- `bias_valid`  out  1  `bias` holds a valid value.
- `bias_count`  out  DEPTH_NB+1  words held in FIFO, not counting the output register.

## Operation
- Accept: on an edge with `up_bias_valid & up_bias_ready`, the formatted word is written at the FIFO tail; `bias_count` increments.
- `up_bias_ready` = `!rst & (bias_count != DEPTH)`, combinational from the registered count.
- Format: sign-extend `up_bias_data`, shift left by `cfg_shift`; result above 2^(N-1)-1 → 0x7FFF (N=16), below -2^(N-1) → 0x8000; otherwise low NUM_WIDTH bits. `cfg_shift`=0 passes unchanged. `cfg_shift` is sampled per word at acceptance.
- Output load: on an edge where (`!bias_valid` or `bias_next`) and FIFO non-empty (pre-edge count), the head moves to `bias`, `bias_valid`←1, count decrements.
- `bias_next` with `bias_valid` high and FIFO empty: `bias_valid`←0; `bias` holds its old value.
- `bias_next` while `bias_valid` low: ignored.
- Simultaneous accept and load: count unchanged; ordering strictly FIFO. A word accepted on the same edge the FIFO is empty is not visible for that edge's load decision.
- No overflow/underflow possible by construction; `bias` never changes unless a load occurs.

## Timing
- Reset (edge with `rst` high): `bias`=0, `bias_valid`=0, `bias_count`=0, FIFO pointers 0; `up_bias_ready`=0 while `rst` high, 1 the first cycle after release.
- Reset mid-operation discards all buffered words and the output value; none appear afterwards.
- Latency, empty block: word accepted on edge E → `bias`/`bias_valid` updated on edge E+1.
- `bias_next` on edge E with FIFO non-empty → next bias presented from edge E (no gap cycle).
- Full: after the 8th FIFO word (9th total with output loaded) `up_bias_ready`=0; a `bias_next` on edge E raises `up_bias_ready` in the cycle after E.
- Pointers wrap modulo DEPTH; count width distinguishes full from empty.

## Test plan
- Reset: hold `rst` 3 cycles with `up_bias_valid`=1 → `bias`=0, `bias_valid`=0, `bias_count`=0, `up_bias_ready`=0; first cycle after release `up_bias_ready`=1, nothing was accepted.
- Basic: `cfg_shift`=4, write 0x0012 on edge E → `bias`=0x0120, `bias_valid`=1 at E+1, `bias_count`=0.
- Saturation: `cfg_shift`=4 with 0x0800 → 0x7FFF; 0xF7FF → 0x8000; 0xFFFF → 0xFFF0; `cfg_shift`=0 with 0x8000 → 0x8000.
- Fill/wrap: write 1..10 with no `bias_next` → `bias`=1, count 8, `up_bias_ready`=0, words 10 stalled; then 12 `bias_next` pulses interleaved with writes → outputs 2..10 in order, pointers wrap, `bias_valid` drops after the last.
- Corner: FIFO empty, `bias_valid`=1, `bias_next` and a write on the same edge → `bias_valid`=0 for one cycle, new word presented next edge; `bias_next` with `bias_valid`=0 → no state change.
- Reset mid-stream: 5 words buffered, `rst` 1 cycle → all outputs reset; subsequent write 0x0003 (`cfg_shift`=0) → `bias`=0x0003, no stale value ever presented.
